ipml_sfifo_fwft_v2_0: RTL

//  Single-clock parametrised FIFO for same-domain buffering such as AXI data staging.

---
 rtl/ipml_sfifo_fwft_v2_0.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ipml_sfifo_fwft_v2_0.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through reads.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   wr_en, wr_data        write request / data; full rejects writes
//   rd_en, rd_data        pop request / read data; empty rejects pops
//   full, almost_full     no space / data_count >= af_thresh
//   empty, almost_empty   no readable word / data_count <= ae_thresh
//   af_thresh, ae_thresh  quasi-static level thresholds
//   data_count            words written and not yet popped (includes prefetch)
//   overflow, underflow   sticky error flags, cleared by err_clr (a new error wins)
module ipml_sfifo_fwft_v2_0 #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WIDTH = 10,
  parameter int unsigned FWFT_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  input  logic [DEPTH_WIDTH:0]  af_thresh,
  input  logic [DEPTH_WIDTH:0]  ae_thresh,
  output logic [DEPTH_WIDTH:0]  data_count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);
  localparam int unsigned      PTR_W    = DEPTH_WIDTH + 1;
  localparam int unsigned      DEPTH    = 1 << DEPTH_WIDTH;
  localparam logic [PTR_W-1:0] CAPACITY = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);
  localparam bit               FWFT     = (FWFT_MODE != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] ram_dout_q, ram_dout_d;
  logic                  ram_valid_q, ram_valid_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_acc;
  logic pop;
  logic out_load;
  logic mem_rd;

  // Next-state: accept decisions, pointers, count, read path and error flags
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    ram_dout_d  = ram_dout_q;
    ram_valid_d = ram_valid_q;
    out_valid_d = out_valid_q;
    empty_d     = empty_q;
    out_load    = 1'b0;
    mem_rd      = 1'b0;

    wr_acc = wr_en & ~full_q;
    pop    = rd_en & ~empty_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end

    case ({wr_acc, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CAPACITY);

    if (FWFT) begin
      // Two-stage prefetch: RAM read register feeds the visible output register.
      // The RAM stage refills on the same edge it hands its word forward, so a
      // pop with a word already in the RAM stage presents the next word with no bubble.
      out_load    = ram_valid_q & (~out_valid_q | pop);
      mem_rd      = (wr_ptr_q != rd_ptr_q) & (~ram_valid_q | out_load);
      if (mem_rd) begin
        rd_ptr_d   = rd_ptr_q + ONE;
        ram_dout_d = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
      end
      ram_valid_d = mem_rd | (ram_valid_q & ~out_load);
      out_valid_d = out_load | (out_valid_q & ~pop);
      if (out_load) begin
        rd_data_d = ram_dout_q;
      end
      empty_d = ~out_valid_d;
    end else begin
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + ONE;
        rd_data_d = mem[rd_ptr_q[DEPTH_WIDTH-1:0]];
      end
      empty_d = (count_d == '0);
    end

    // A new error in the same cycle as err_clr keeps the flag set
    overflow_d  = (wr_en & full_q)  | (overflow_q  & ~err_clr);
    underflow_d = (rd_en & empty_q) | (underflow_q & ~err_clr);
  end

  // Control and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_data_q   <= '0;
      ram_dout_q  <= '0;
      ram_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rd_data_q   <= rd_data_d;
      ram_dout_q  <= ram_dout_d;
      ram_valid_q <= ram_valid_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign rd_data    = rd_data_q;
  assign data_count = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  // Level flags follow the count register, so they move on the same edge as
  // data_count and hold (af_thresh == 0) / 1 while in reset.
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);

endmodule
